// File: rtl/ascii_encoder_if.sv
// Handshake bundle for the binary-to-ASCII encoder:
// start/value request side plus the character stream.
interface ascii_encoder_if;
    logic        start;
    logic [19:0] bin_in;
    logic        busy;
    logic        done;
    logic [7:0]  ascii_out;
    logic        ascii_valid;
    logic        ascii_ready;

    modport master (
        output start,
        output bin_in,
        output ascii_ready,
        input  busy,
        input  done,
        input  ascii_out,
        input  ascii_valid
    );

    modport slave (
        input  start,
        input  bin_in,
        input  ascii_ready,
        output busy,
        output done,
        output ascii_out,
        output ascii_valid
    );
endinterface

// File: rtl/ascii_encoder.sv
// 20-bit binary to 7-digit ASCII decimal, MSD first, via
// double-dabble followed by a valid/ready character stream.
module ascii_encoder #(
    parameter bit SUPPRESS_ZEROS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    ascii_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT
    } state_t;

    state_t      state, state_nx;
    logic [19:0] bin, bin_nx;
    logic [27:0] bcd, bcd_nx, bcd_adj;
    logic [4:0]  cnt, cnt_nx;
    logic [2:0]  idx, idx_nx;
    logic        seen, seen_nx;
    logic        valid, valid_nx;
    logic [7:0]  out, out_nx;
    logic        busy, busy_nx;
    logic        done, done_nx;

    logic        load;
    logic [27:0] load_bcd;
    logic [2:0]  load_idx;

    function automatic logic [3:0] digit_at(
        input logic [27:0] b,
        input logic [2:0]  i
    );
        return b[{i, 2'b00} +: 4];
    endfunction

    function automatic logic hide(
        input logic [27:0] b,
        input logic [2:0]  i,
        input logic        s
    );
        return SUPPRESS_ZEROS && !s &&
               (digit_at(b, i) == 4'd0) && (i != 3'd0);
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 7; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        bin_nx   = bin;
        bcd_nx   = bcd;
        cnt_nx   = cnt;
        idx_nx   = idx;
        seen_nx  = seen;
        valid_nx = valid;
        out_nx   = out;
        busy_nx  = busy;
        done_nx  = 1'b0;
        load     = 1'b0;
        load_bcd = bcd;
        load_idx = idx;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    bin_nx   = bus.bin_in;
                    bcd_nx   = '0;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_nx, bin_nx} = {bcd_adj[26:0], bin, 1'b0};
                cnt_nx = cnt + 5'd1;
                if (cnt == 5'd19) begin
                    state_nx = EMIT;
                    seen_nx  = 1'b0;
                    load     = 1'b1;
                    load_bcd = bcd_nx;
                    load_idx = 3'd6;
                end
            end
            EMIT: begin
                if (!valid || bus.ascii_ready) begin
                    if (valid && idx == 3'd0) begin
                        state_nx = IDLE;
                        valid_nx = 1'b0;
                        out_nx   = 8'h00;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        load     = 1'b1;
                        load_idx = idx - 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Output flops are loaded with the decision for the next digit
        // so the character is registered when its position is entered.
        if (load) begin
            idx_nx = load_idx;
            if (hide(load_bcd, load_idx, seen_nx)) begin
                valid_nx = 1'b0;
                out_nx   = 8'h00;
            end else begin
                valid_nx = 1'b1;
                out_nx   = {4'h3, digit_at(load_bcd, load_idx)};
                seen_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            idx   <= '0;
            seen  <= 1'b0;
            valid <= 1'b0;
            out   <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            bin   <= bin_nx;
            bcd   <= bcd_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            seen  <= seen_nx;
            valid <= valid_nx;
            out   <= out_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.ascii_out   = out;
    assign bus.ascii_valid = valid;
endmodule
